// File: rtl/seq_shifter.sv
// Multi-cycle barrel shifter: processes one log2 stage per clock (SLL/SRL/SRA/ROR),
// so latency is fixed at SHAMT_W cycles regardless of shift amount or mode.
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nx;
  logic [SHAMT_W-1:0] stg;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         mode_q;
  logic               sign_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_stage;
  logic [WIDTH-1:0]   ones;
  logic [WIDTH-1:0]   hi_mask;
  logic [SHAMT_W-1:0] step;
  logic [SHAMT_W-1:0] back;

  localparam logic [SHAMT_W-1:0] LAST_STG = SHAMT_W'(SHAMT_W - 1);

  // Shift of acc by 2^stg; step never exceeds WIDTH/2, so back = WIDTH-step fits SHAMT_W bits.
  always_comb begin
    step      = SHAMT_W'(1) << stg;
    back      = SHAMT_W'(WIDTH - int'(step));
    ones      = '1;
    hi_mask   = ~(ones >> step);
    acc_stage = acc;
    case (mode_q)
      2'b00:   acc_stage = acc << step;
      2'b01:   acc_stage = acc >> step;
      2'b10:   acc_stage = (acc >> step) | (hi_mask & {WIDTH{sign_q}});
      default: acc_stage = (acc >> step) | (acc << back);
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)       state_nx = SHIFT;
      SHIFT:   if (stg == LAST_STG) state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      stg     <= '0;
      acc     <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc     <= in_data;
            shamt_q <= in_shamt;
            mode_q  <= in_mode;
            sign_q  <= in_data[WIDTH-1];
            stg     <= '0;
          end
        end
        SHIFT: begin
          if (shamt_q[stg]) acc <= acc_stage;
          stg <= stg + SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = acc;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed vector table on a 32-bit shifter plus multi-cycle corner sequences,
// and a random sweep of an 8-bit build against a single-cycle reference.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_data8, out_data8;
  logic [2:0]  in_shamt8;
  logic [1:0]  in_mode8;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  seq_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .in_shamt(in_shamt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
  );

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Accept one request, measure cycles to out_valid; optionally leave result in DONE.
  task automatic issue32(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                         output int lat);
    @(negedge clk);
    in_data = d; in_shamt = s; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 32'h5A5A_A5A5; in_shamt = 5'd31; in_mode = 2'b11;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic run32(input string name, input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] m, input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    issue32(d, s, m, lat);
    chk({name, "_lat"}, lat, 32'd5);
    chk(name, out_data, exp);
    @(posedge clk); #1;
    chk({name, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
    logic signed [7:0] sd;
    sd = d;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
      default: return (s == 3'd0) ? d : ((d >> s) | (d << (8 - int'(s))));
    endcase
  endfunction

  initial begin
    int lat;
    logic [31:0] held;
    logic        seen;
    logic [7:0]  d8;
    logic [2:0]  s8;
    logic [1:0]  m8;

    vecs.push_back('{"sll_10_2",     2'b00, 32'd10,        5'd2,  32'd40});
    vecs.push_back('{"sll_100_2",    2'b00, 32'd100,       5'd2,  32'd400});
    vecs.push_back('{"sra_msb_4",    2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000});
    vecs.push_back('{"srl_msb_4",    2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000});
    vecs.push_back('{"ror_1_1",      2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000});
    vecs.push_back('{"s0_sll",       2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
    vecs.push_back('{"s0_srl",       2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
    vecs.push_back('{"s0_sra",       2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
    vecs.push_back('{"s0_ror",       2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF});
    vecs.push_back('{"sll_ones_31",  2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000});
    vecs.push_back('{"sra_pos_31",   2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000});
    vecs.push_back('{"sra_neg_31",   2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF});
    vecs.push_back('{"ror_nib_4",    2'b11, 32'h1234_5678, 5'd4,  32'h8123_4567});
    vecs.push_back('{"ror_msb_31",   2'b11, 32'h8000_0000, 5'd31, 32'h0000_0001});
    vecs.push_back('{"srl_f0_16",    2'b01, 32'hF0F0_F0F0, 5'd16, 32'h0000_F0F0});
    vecs.push_back('{"sll_byte_8",   2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800});
    vecs.push_back('{"sra_neg_21",   2'b10, 32'hA000_0000, 5'd21, 32'hFFFF_FD00});

    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd3; in_mode = 2'b00;
    out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    // in_valid was high across reset edges: nothing may have been accepted
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_accept", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run32(vecs[i].name, vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].exp);

    // Backpressure with inputs toggling during DONE
    out_ready = 1'b0;
    issue32(32'd100, 5'd2, 2'b00, lat);
    chk("bp_lat", lat, 32'd5);
    held = out_data;
    chk("bp_data", held, 32'd400);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_shamt = 5'd1; in_mode = 2'b01;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data",  out_data, held);
      chk("bp_hold_nrdy",  {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_rdy",   {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_same_edge_accept", {31'd0, in_ready}, 32'd1);

    // Reset while processing stage 2
    @(negedge clk);
    in_data = 32'hDEAD_BEEF; in_shamt = 5'd7; in_mode = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data",  out_data, 32'd0);
    chk("midrst_rdy",   {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_stale", {31'd0, seen}, 32'd0);

    // WIDTH=8 random sweep
    for (int t = 0; t < 1000; t++) begin
      d8 = 8'($urandom_range(0, 255));
      s8 = 3'($urandom_range(0, 7));
      m8 = 2'($urandom_range(0, 3));
      @(negedge clk);
      in_data8 = d8; in_shamt8 = s8; in_mode8 = m8; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0; in_data8 = ~d8;
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (out_valid8) begin lat = c; break; end
      end
      chk("w8_lat", lat, 32'd3);
      chk("w8_data", {24'd0, out_data8}, {24'd0, ref8(d8, s8, m8)});
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width; power of two, >= 2.
REQ-002 SHALL have derived parameter SHAMT_W, default $clog2(WIDTH) = 5: shift-amount width and stage count.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: request present.
REQ-006 SHALL have port in_ready  output  1: block can accept a request.
REQ-007 SHALL have port in_data  input  WIDTH: operand.
REQ-008 SHALL have port in_shamt  input  SHAMT_W: shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_mode  input  2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-010 SHALL have port out_valid  output  1: result present.
REQ-011 SHALL have port out_ready  input  1: consumer takes the result.
REQ-012 SHALL have port out_data  output  WIDTH: shifted result.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE, plus stage counter stg (0..SHAMT_W-1), working register acc, and latched shamt, mode and sign.
REQ-014 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-015 SHALL accept a request on an edge with in_valid && in_ready.
- On acceptance: acc<=in_data; latch shamt and mode; sign<=in_data[WIDTH-1]; stg<=0; IDLE->SHIFT.
REQ-016 SHALL, on each SHIFT edge, process stage stg.
- If shamt[stg]=1: acc is shifted by 2^stg per the latched mode.
- If shamt[stg]=0: acc is unchanged.
- stg increments.
REQ-017 SHALL apply these per-mode fill rules in each SHIFT stage:
- SLL: zero-fill LSBs.
- SRL: zero-fill MSBs.
- SRA: fill MSBs with the latched sign.
- ROR: bits shifted out of the LSB re-enter at the MSB.
REQ-018 SHALL, on the edge that processes stg=SHAMT_W-1, go SHIFT->DONE; out_valid therefore rises exactly SHAMT_W cycles after the acceptance edge (5 for WIDTH=32).
REQ-019 SHALL make latency independent of shamt and mode; shamt=0 still takes SHAMT_W cycles and returns in_data unchanged.
REQ-020 SHALL drive out_data=acc in all states; only values while out_valid=1 are meaningful.
REQ-021 SHALL hold out_data and out_valid stable in DONE while out_ready=0 (backpressure, unbounded).
REQ-022 SHALL go DONE->IDLE on an edge with out_valid && out_ready; no new request is accepted on that same edge. Minimum request spacing is SHAMT_W+2 cycles.
REQ-023 SHALL ignore in_valid, in_data, in_shamt and in_mode outside IDLE; latched values are not disturbed.
REQ-024 SHALL ignore out_ready outside DONE.
REQ-025 SHALL produce results equal to the single-cycle reference: SLL in<<s; SRL in>>s; SRA $signed(in)>>>s; ROR (in>>s)|(in<<(WIDTH-s)), with s=0 giving in.
REQ-026 SHALL never produce X on outputs after the first reset edge, for any parameter value meeting REQ-001.

Reset
REQ-027 SHALL, on any edge with rst_n=0, set state=IDLE, stg=0 and acc=0, giving in_ready=1 (after reset release), out_valid=0, out_data=0.
REQ-028 SHALL let reset override every state; a request in SHIFT or DONE is discarded without producing a result.
REQ-029 SHALL block acceptance on an edge where rst_n=0 even if in_valid=1.

Verification
REQ-030 SHALL cover: WIDTH=32, SLL, data=10, shamt=2 -> out_valid 5 cycles after accept, out_data=40; data=100 -> 400.
REQ-031 SHALL cover: SRA, data=0x80000000, shamt=4 -> 0xF8000000; SRL with the same inputs -> 0x08000000.
REQ-032 SHALL cover: ROR, data=0x00000001, shamt=1 -> 0x80000000; shamt=0, any mode, data=0xDEADBEEF -> 0xDEADBEEF after 5 cycles.
REQ-033 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 SHALL cover: rst_n=0 during SHIFT stage 2 -> next cycle out_valid=0, out_data=0, in_ready=1; no stale result appears later.
REQ-035 SHALL cover: WIDTH=8 build with random data/shamt/mode, 1000 transactions -> every result matches REQ-025 and latency is 3 cycles.
